seg7_multiplex_display: RTL

Registered, parametrised 7-segment display controller for the guessing-number game. It drives DIGITS active-low 7-segment displays from packed BCD guess data. In lose mode it alternates on an internal timer between the data and the decimal trial count. An on-chip sequential binary-to-BCD converter produces that count.

---
 rtl/seg7_multiplex_display.sv | 131 +++++++++++++
 1 files changed

// File: rtl/seg7_multiplex_display.sv
// seg7_multiplex_display: multiplexed active-low 7-segment driver with lose-mode data/count alternation.
// Define SEG7_HEX_EN to show hex letters A-F for nibbles 10-15 instead of a dash.
module seg7_multiplex_display #(
    parameter int DIGITS     = 4,
    parameter int CNT_W      = 4,
    parameter int CNT_DIGITS = 2,
    parameter int ALT_PERIOD = 25_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  state,
    input  logic                  count_over,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [CNT_W-1:0]      cnt,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  cnt_phase
);
    localparam int TW = $clog2(ALT_PERIOD);
    localparam int IW = $clog2(CNT_W + 1);
    localparam int BW = 4 * CNT_DIGITS;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'd0:    glyph = 7'b0000001;
            4'd1:    glyph = 7'b1001111;
            4'd2:    glyph = 7'b0010010;
            4'd3:    glyph = 7'b0000110;
            4'd4:    glyph = 7'b1001100;
            4'd5:    glyph = 7'b0100100;
            4'd6:    glyph = 7'b0100000;
            4'd7:    glyph = 7'b0001111;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0000100;
`ifdef SEG7_HEX_EN
            4'hA:    glyph = 7'b0001000;
            4'hB:    glyph = 7'b1100000;
            4'hC:    glyph = 7'b0110001;
            4'hD:    glyph = 7'b1000010;
            4'hE:    glyph = 7'b0110000;
            default: glyph = 7'b0111000;
`else
            default: glyph = 7'b1111110;
`endif
        endcase
    endfunction

    logic [TW-1:0]       r_timer;
    logic                r_phase;
    logic                r_busy;
    logic [IW-1:0]       r_iter;
    logic [BW+CNT_W-1:0] r_work;
    logic [CNT_W-1:0]    r_src;
    logic [CNT_W-1:0]    r_last;
    logic [BW-1:0]       r_bcd;

    logic                w_alt;
    logic                w_wrap;
    logic                w_data_mode;
    logic                w_cnt_mode;
    logic [BW-1:0]       w_adj;
    logic [BW+CNT_W-1:0] w_step;
    logic [7*DIGITS-1:0] w_seg;

    assign w_alt       = state & count_over;
    assign w_wrap      = r_timer == TW'(ALT_PERIOD - 1);
    assign w_data_mode = state & (count_over ? ~r_phase : en);
    assign w_cnt_mode  = w_alt & r_phase;

    // Timer and phase sit at zero outside ALT_*, so entering always starts in ALT_DATA.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
            r_phase <= 1'b0;
        end else if (!w_alt) begin
            r_timer <= '0;
            r_phase <= 1'b0;
        end else begin
            r_timer <= w_wrap ? '0 : r_timer + 1'b1;
            r_phase <= r_phase ^ w_wrap;
        end
    end

    // r_work holds {bcd accumulator, remaining binary bits}; each cycle is one add-3-then-shift step.
    for (genvar j = 0; j < CNT_DIGITS; j++) begin : g_adj
        assign w_adj[4*j+:4] = r_work[CNT_W+4*j+:4] >= 4'd5 ? r_work[CNT_W+4*j+:4] + 4'd3 : r_work[CNT_W+4*j+:4];
    end
    assign w_step = {w_adj, r_work[CNT_W-1:0]} << 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_iter <= '0;
            r_work <= '0;
            r_src  <= '0;
            r_last <= '0;
            r_bcd  <= '0;
        end else if (r_busy) begin
            r_work <= w_step;
            r_iter <= r_iter + 1'b1;
            if (r_iter == IW'(CNT_W - 1)) begin
                r_busy <= 1'b0;
                r_bcd  <= w_step[BW+CNT_W-1:CNT_W];
                r_last <= r_src;
            end
        end else if (cnt != r_last) begin
            r_busy <= 1'b1;
            r_iter <= '0;
            r_work <= {{BW{1'b0}}, cnt};
            r_src  <= cnt;
        end
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_dig
        if (k < CNT_DIGITS) begin : g_cnt
            assign w_seg[7*k+:7] = w_cnt_mode ? glyph(r_bcd[4*k+:4]) : w_data_mode ? glyph(data[4*k+:4]) : 7'h7f;
        end else begin : g_dat
            assign w_seg[7*k+:7] = w_data_mode ? glyph(data[4*k+:4]) : 7'h7f;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg       <= '1;
            cnt_phase <= 1'b0;
        end else begin
            seg       <= w_seg;
            cnt_phase <= w_cnt_mode;
        end
    end
endmodule
